// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Word-wide memory responder with a fixed request-to-response
//            latency, little-endian byte array and alignment/range checking.
// Revision : 1.0
// ============================================================================
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         c_depth  = 2 ** ADDR_W;
    localparam logic [3:0] c_lat_m1 = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    logic        r_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [7:0]  r_mem [c_depth];

    logic        w_live;
    logic        w_op_wr;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;
    logic [3:0]  w_op_be;
    logic        w_err;
    logic [31:0] w_rword;
    logic [ADDR_W-1:0] w_lane_addr [4];

    logic        w_capture;
    logic        w_enter_resp;
    logic        w_commit;
    logic        w_ready_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_rdata_nxt;
    logic        w_err_nxt;

    // With LATENCY=1 the accept edge is also the edge entering RESP, so the
    // operation is taken straight from the bus instead of the capture regs.
    assign w_live     = (r_state == IDLE);
    assign w_op_wr    = w_live ? req_wr    : r_wr;
    assign w_op_addr  = w_live ? req_addr  : r_addr;
    assign w_op_wdata = w_live ? req_wdata : r_wdata;
    assign w_op_be    = w_live ? req_be    : r_be;

    assign w_err = (w_op_addr[1:0] != 2'b00) || ((w_op_addr >> ADDR_W) != 32'd0);

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign w_lane_addr[k]  = {w_op_addr[ADDR_W-1:2], 2'(k)};
            assign w_rword[8*k+:8] = r_mem[w_lane_addr[k]];
        end
    endgenerate

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ready_nxt  = req_ready;
        w_valid_nxt  = 1'b0;
        w_rdata_nxt  = resp_rdata;
        w_err_nxt    = resp_err;
        w_capture    = 1'b0;
        w_enter_resp = 1'b0;

        case (r_state)
            IDLE: begin
                w_ready_nxt = 1'b1;
                w_err_nxt   = 1'b0;
                if (req_valid) begin
                    w_capture   = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_cnt_nxt   = c_lat_m1;
                    if (LATENCY == 1) begin
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b1;
                w_err_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b1;
            end
        endcase

        if (w_enter_resp) begin
            w_state_nxt = RESP;
            w_ready_nxt = 1'b0;
            w_valid_nxt = 1'b1;
            w_err_nxt   = w_err;
            w_rdata_nxt = (w_err || w_op_wr) ? 32'd0 : w_rword;
        end
    end

    assign w_commit = reset && w_enter_resp && w_op_wr && !w_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            req_ready  <= w_ready_nxt;
            resp_valid <= w_valid_nxt;
            resp_rdata <= w_rdata_nxt;
            resp_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_capture) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Array contents survive reset; only the commit strobe is reset-gated.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_op_be[k]) begin
                    r_mem[w_lane_addr[k]] <= w_op_wdata[8*k+:8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Three responders (LATENCY 1, 2, 5) on one request bus, checked
//            cycle by cycle against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_mem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rdy  [N];
    logic        vld  [N];
    logic        rerr [N];
    logic [31:0] rdat [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(rdy[0]), .resp_valid(vld[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0])
    );
    mem_responder #(.ADDR_W(8), .LATENCY(2)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(rdy[1]), .resp_valid(vld[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1])
    );
    mem_responder #(.ADDR_W(8), .LATENCY(5)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(rdy[2]), .resp_valid(vld[2]), .resp_rdata(rdat[2]), .resp_err(rerr[2])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 5;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d (LATENCY=%0d) t=%0t: got 0x%08h, expected 0x%08h",
                     name, i, lat_of(i), $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_mem   [N][256];
    bit          m_known [N][256];
    int          m_busy  [N];
    bit          m_valid [N];
    bit          m_ready [N];
    bit          m_err   [N];
    logic [31:0] m_rdata [N];
    logic [31:0] m_mask  [N];
    bit          m_wr    [N];
    logic [31:0] m_addr  [N];
    logic [31:0] m_wd    [N];
    logic [3:0]  m_be    [N];
    bit          started = 1'b0;

    task automatic model_respond(input int i);
        bit e;
        int a;
        e = (m_addr[i][1:0] != 2'b00) || (m_addr[i] >= 32'd256);
        m_valid[i] = 1'b1;
        m_err[i]   = e;
        m_rdata[i] = 32'd0;
        m_mask[i]  = 32'hFFFF_FFFF;
        if (!e) begin
            a = int'(m_addr[i]);
            for (int k = 0; k < 4; k++) begin
                if (m_wr[i]) begin
                    if (m_be[i][k]) begin
                        m_mem[i][a+k]   = m_wd[i][8*k+:8];
                        m_known[i][a+k] = 1'b1;
                    end
                end else begin
                    m_rdata[i][8*k+:8] = m_mem[i][a+k];
                    if (!m_known[i][a+k]) m_mask[i][8*k+:8] = 8'h00;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                m_busy[i]  = 0;
                m_valid[i] = 1'b0;
                m_ready[i] = 1'b1;
                m_err[i]   = 1'b0;
                m_rdata[i] = 32'd0;
                m_mask[i]  = 32'hFFFF_FFFF;
                started    = 1'b1;
            end else if (m_valid[i]) begin
                m_valid[i] = 1'b0;
                m_ready[i] = 1'b1;
                m_err[i]   = 1'b0;
            end else if (m_busy[i] > 0) begin
                m_busy[i]--;
                if (m_busy[i] == 0) model_respond(i);
            end else if (req_valid) begin
                m_wr[i]    = req_wr;
                m_addr[i]  = req_addr;
                m_wd[i]    = req_wdata;
                m_be[i]    = req_be;
                m_ready[i] = 1'b0;
                m_busy[i]  = lat_of(i) - 1;
                if (m_busy[i] == 0) model_respond(i);
            end
        end
    end

    // ---------------- per-cycle compare + response monitor ----------------
    int          resp_cnt   [N];
    int          resp_cyc   [N];
    logic [31:0] last_rdata [N];
    logic        last_err   [N];

    initial for (int i = 0; i < N; i++) resp_cnt[i] = 0;

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < N; i++) begin
                chk("req_ready", i, 32'(rdy[i]), 32'(m_ready[i]));
                chk("resp_valid", i, 32'(vld[i]), 32'(m_valid[i]));
                if (m_valid[i]) begin
                    chk("resp_err", i, 32'(rerr[i]), 32'(m_err[i]));
                    chk("resp_rdata", i, rdat[i] & m_mask[i], m_rdata[i] & m_mask[i]);
                end
                if (vld[i] === 1'b1) begin
                    resp_cnt[i]++;
                    resp_cyc[i]   = cyc;
                    last_rdata[i] = rdat[i];
                    last_err[i]   = rerr[i];
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        int t0;
        int base [N];
        @(posedge clk); #1;
        req_wr = wr; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
        t0 = cyc;
        for (int i = 0; i < N; i++) base[i] = resp_cnt[i];
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("resp_count", i, 32'(resp_cnt[i]), 32'(base[i] + 1));
            chk("latency", i, 32'(resp_cyc[i] - t0), 32'(lat_of(i)));
        end
    endtask

    task automatic chk_resp(input string name, input logic [31:0] exp_rd, input bit exp_err);
        for (int i = 0; i < N; i++) begin
            chk({name, "_rdata"}, i, last_rdata[i], exp_rd);
            chk({name, "_err"}, i, 32'(last_err[i]), 32'(exp_err));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          base [N];
        int          acc  [N];
        int          r;
        logic [31:0] a;

        reset = 1'b0; req_valid = 1'b1; req_wr = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_ready", i, 32'(rdy[i]), 32'd1);
            chk("rst_valid", i, 32'(vld[i]), 32'd0);
            chk("rst_rdata", i, rdat[i], 32'd0);
            chk("rst_err", i, 32'(rerr[i]), 32'd0);
        end
        reset = 1'b1; req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) chk("rst_no_resp", i, 32'(resp_cnt[i]), 32'd0);

        do_req(1'b1, 32'h00, 32'h55AA_1234, 4'hF);
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        chk_resp("wr_full", 32'd0, 1'b0);
        do_req(1'b0, 32'h10, 32'd0, 4'h0);
        chk_resp("rd_full", 32'hDEAD_BEEF, 1'b0);
        chk("model_byte10", 1, 32'(m_mem[1][8'h10]), 32'hEF);
        chk("model_byte13", 1, 32'(m_mem[1][8'h13]), 32'hDE);

        do_req(1'b1, 32'h10, 32'h1122_3344, 4'b0101);
        do_req(1'b0, 32'h10, 32'd0, 4'h0);
        chk_resp("rd_partial", 32'hDE22_BE44, 1'b0);

        do_req(1'b0, 32'h12, 32'd0, 4'h0);
        chk_resp("rd_misalign", 32'd0, 1'b1);
        do_req(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF);
        chk_resp("wr_range", 32'd0, 1'b1);
        do_req(1'b0, 32'h00, 32'd0, 4'h0);
        chk_resp("rd_after_err", 32'h55AA_1234, 1'b0);

        do_req(1'b1, 32'h10, 32'h0000_0000, 4'b0000);
        chk_resp("wr_be0", 32'd0, 1'b0);
        do_req(1'b0, 32'h10, 32'd0, 4'h0);
        chk_resp("rd_be0", 32'hDE22_BE44, 1'b0);

        // reset in the cycle after the accept edge
        do_req(1'b1, 32'h20, 32'h0102_0304, 4'hF);
        @(posedge clk); #1;
        req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D; req_be = 4'hF; req_valid = 1'b1;
        for (int i = 0; i < N; i++) base[i] = resp_cnt[i];
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("midrst_count", 0, 32'(resp_cnt[0]), 32'(base[0] + 1));
        chk("midrst_count", 1, 32'(resp_cnt[1]), 32'(base[1]));
        chk("midrst_count", 2, 32'(resp_cnt[2]), 32'(base[2]));
        do_req(1'b0, 32'h20, 32'd0, 4'h0);
        chk("midrst_rd", 0, last_rdata[0], 32'hCAFE_F00D);
        chk("midrst_rd", 1, last_rdata[1], 32'h0102_0304);
        chk("midrst_rd", 2, last_rdata[2], 32'h0102_0304);

        // req_valid held high: one accept per LATENCY+1 cycles
        @(posedge clk); #1;
        req_wr = 1'b0; req_addr = 32'h00; req_valid = 1'b1;
        for (int i = 0; i < N; i++) acc[i] = 0;
        repeat (24) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (rdy[i] === 1'b1) acc[i]++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("burst_accepts", 0, 32'(acc[0]), 32'd12);
        chk("burst_accepts", 1, 32'(acc[1]), 32'd8);
        chk("burst_accepts", 2, 32'(acc[2]), 32'd4);

        // randomized traffic with occasional resets
        repeat (800) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 99) != 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_wr    = 1'($urandom_range(0, 1));
            a         = 32'($urandom_range(0, 15)) << 2;
            r         = int'($urandom_range(0, 15));
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = a | (32'd1 << $urandom_range(8, 31));
            req_addr  = a;
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
        end
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory bus. The CPU is the initiator; this block accepts word read/write requests over a valid/ready handshake.
- It serves each request from an internal byte array after a fixed, parameterised latency, then returns a one-cycle response with read data and an error flag.
- It replaces the zero-wait memory model so the control unit and datapath can be exercised against wait states.

Parameters:
- ADDR_W, 8: byte-address width of the array; capacity is 2^ADDR_W bytes (2^(ADDR_W-2) words).
- LATENCY, 2: number of clock edges from request accept to response. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  initiator presents a request.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data; byte lane k is bits [8k+7:8k].
- req_be  input  4  write byte enables, one per lane; ignored on reads.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  read data; valid only while resp_valid=1.
- resp_err  output  1  request was rejected; valid only while resp_valid=1.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Any in-flight request is discarded; a pending write is not committed.
  - Array contents are not reset.
  - Requests presented while reset=0 are ignored.
- Endianness: little-endian. Byte lane k of the word at aligned address a is array[a+k].
- Accept rule:
  - A request is accepted at an edge where req_valid=1, req_ready=1 and reset=1.
  - req_wr, req_addr, req_wdata and req_be are captured at that edge; later input changes have no effect.
- Error check, evaluated on the captured request:
  - err=1 if req_addr[1:0]!=0 (misaligned).
  - err=1 if req_addr >= 2^ADDR_W (any bit above ADDR_W-1 set).
- FSM states: IDLE, WAIT, RESP. req_ready=1 only in IDLE; all outputs are registered.
  - IDLE, on accept: load cnt=LATENCY-1. Go to RESP if LATENCY=1, otherwise go to WAIT.
  - WAIT: decrement cnt each edge. When cnt==1, the edge moves to RESP.
  - Edge entering RESP:
    - read without err: resp_rdata = word at the captured address.
    - write without err: lanes with be[k]=1 are written into the array; resp_rdata=0.
    - err: the array is unchanged, resp_rdata=0, resp_err=1.
  - RESP: resp_valid=1 for exactly one cycle. The next edge returns to IDLE, clears resp_valid and resp_err, and sets req_ready=1.
- Timing:
  - resp_valid is high in the cycle after the LATENCY-th edge counted from the accept edge.
  - Minimum request spacing is LATENCY+1 cycles; back-to-back accept is impossible because RESP does not accept.
- Write with req_be=0000: legal no-op, resp_err=0.
- Read-after-write to the same address returns the new data, because the write is committed on entry to RESP.
- No backpressure on the response: the initiator must sample resp_* in the RESP cycle.
- Reset on the same edge as an accept: reset wins and the request is dropped.

Test Plan (ADDR_W=8, LATENCY=2 unless stated):
- Reset: hold reset=0 for 2 cycles with req_valid=1 -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, and no response follows after reset release without a new accept.
- Write then read:
  - write addr=0x10, wdata=0xDEADBEEF, be=1111 -> resp_valid exactly 2 edges after accept, resp_err=0.
  - then read 0x10 -> resp_rdata=0xDEADBEEF; array[0x10]=0xEF and array[0x13]=0xDE.
- Partial write: write addr=0x10, wdata=0x11223344, be=0101, then read 0x10 -> 0xDE22BE44.
- Errors:
  - read addr=0x12 -> resp_err=1, resp_rdata=0.
  - write addr=0x100 -> resp_err=1, and a following read of 0x00 returns its prior value unchanged.
- Latency sweep:
  - LATENCY=1 -> resp_valid in the cycle right after the accept edge, req_ready=0 for exactly 1 cycle.
  - LATENCY=5 -> req_ready low for 5 cycles, resp_valid pulses once.
  - In both cases, holding req_valid=1 continuously yields one accept per LATENCY+1 cycles.
- Reset mid-operation: accept write addr=0x20, wdata=0xCAFEF00D, assert reset=0 in the WAIT cycle -> no resp_valid; a later read of 0x20 returns its pre-write value.
